// File: rtl/output_scheduler.sv
// Output scheduler: round-robin arbiter that moves whole packets from three FWFT channel FIFOs to one byte output.
// Latency: 1 pick cycle, then 2 cycles per byte (request + gap) when the downstream acks at once.
// Backpressure: data_out_req is held until data_out_ack; a drained granted FIFO parks the packet with req low.
//
// Ports:
//   clk, rst_n                 - clock (rising edge) and asynchronous active-low reset
//   fifo_empty[2:0]            - per-channel empty flags
//   fifo_data0/1/2             - first-word-fall-through heads of the channel FIFOs
//   fifo_pop[2:0]              - one-cycle pop pulse to the granted channel on a handshake
//   crc_en                     - packet carries a trailing CRC byte (sampled at header ack)
//   data_out / data_out_req    - output byte and its request
//   data_out_ack               - downstream accepts the byte
//   grant[2:0] / busy          - one-hot owner of the output / packet in flight
module output_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_SIZE  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data0,
    input  logic [DATA_WIDTH-1:0] fifo_data1,
    input  logic [DATA_WIDTH-1:0] fifo_data2,
    output logic [2:0]            fifo_pop,
    input  logic                  crc_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_req,
    input  logic                  data_out_ack,
    output logic [2:0]            grant,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, HEADER, DATA, GAP} state_t;

    state_t               state;
    logic [DATA_SIZE:0]   rem_r;
    logic [1:0]           last_grant;
    logic                 end_pkt;

    logic                 pick_vld;
    logic [1:0]           pick_idx;
    logic                 gnt_avail;
    logic                 xfer;
    logic [DATA_SIZE:0]   hdr_rem;

    // Round-robin search: last_grant+1 has highest priority, so walk the
    // candidates from lowest to highest priority and let the last hit win.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            int c;
            c = (int'(last_grant) + k) % 3;
            if (!fifo_empty[c]) begin
                pick_vld = 1'b1;
                pick_idx = 2'(c);
            end
        end
    end

    always_comb begin
        case (grant)
            3'b001:  data_out = fifo_data0;
            3'b010:  data_out = fifo_data1;
            3'b100:  data_out = fifo_data2;
            default: data_out = '0;
        endcase
    end

    assign gnt_avail = |(grant & ~fifo_empty);
    // Req is only ever raised while the granted FIFO holds data, so a pop
    // can never hit an empty FIFO and at most one bit is set.
    assign xfer      = data_out_req & data_out_ack;
    assign fifo_pop  = xfer ? grant : 3'b000;
    // Header size plus optional CRC byte; one extra bit so 2^DATA_SIZE-1+1 fits.
    assign hdr_rem   = {1'b0, data_out[DATA_SIZE-1:0]} + {{DATA_SIZE{1'b0}}, crc_en};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= 3'b000;
            busy         <= 1'b0;
            data_out_req <= 1'b0;
            rem_r        <= '0;
            last_grant   <= 2'd2;
            end_pkt      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        // Picked FIFO is non-empty, so the header request can go out at once.
                        grant        <= 3'b001 << pick_idx;
                        last_grant   <= pick_idx;
                        busy         <= 1'b1;
                        data_out_req <= 1'b1;
                        state        <= HEADER;
                    end
                end
                HEADER: begin
                    if (xfer) begin
                        data_out_req <= 1'b0;
                        rem_r        <= hdr_rem;
                        end_pkt      <= (hdr_rem == '0);
                        state        <= GAP;
                    end else if (!data_out_req) begin
                        data_out_req <= gnt_avail;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        data_out_req <= 1'b0;
                        rem_r        <= rem_r - (DATA_SIZE+1)'(1);
                        end_pkt      <= (rem_r == (DATA_SIZE+1)'(1));
                        state        <= GAP;
                    end else if (!data_out_req) begin
                        data_out_req <= gnt_avail;
                    end
                end
                GAP: begin
                    // The FIFO flags already reflect the pop of the previous cycle here.
                    if (end_pkt) begin
                        state   <= IDLE;
                        grant   <= 3'b000;
                        busy    <= 1'b0;
                        end_pkt <= 1'b0;
                    end else begin
                        state        <= DATA;
                        data_out_req <= gnt_avail;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_scheduler.sv
// Directed bench for output_scheduler with three behavioural FWFT channel FIFOs.
module tb_output_scheduler;

    logic       clk;
    logic       rst_n;
    logic [2:0] fifo_empty;
    logic [7:0] fifo_data0, fifo_data1, fifo_data2;
    logic [2:0] fifo_pop;
    logic       crc;
    logic [7:0] data_out;
    logic       data_out_req;
    logic       ack;
    logic [2:0] grant;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Channel FIFO models: 256-entry rings, pointers wrap naturally.
    logic [7:0] mem [3][256];
    logic [7:0] rd [3];
    logic [7:0] wr [3];
    logic       flush;
    int         viol = 0;
    int         log_ch[$];
    logic [7:0] log_dat[$];

    output_scheduler #(.DATA_WIDTH(8), .DATA_SIZE(6)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty),
        .fifo_data0(fifo_data0), .fifo_data1(fifo_data1), .fifo_data2(fifo_data2),
        .fifo_pop(fifo_pop), .crc_en(crc), .data_out(data_out),
        .data_out_req(data_out_req), .data_out_ack(ack), .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = {rd[2] == wr[2], rd[1] == wr[1], rd[0] == wr[0]};
    assign fifo_data0 = mem[0][rd[0]];
    assign fifo_data1 = mem[1][rd[1]];
    assign fifo_data2 = mem[2][rd[2]];

    always @(posedge clk) begin
        if ($countones(fifo_pop) > 1) viol++;
        for (int i = 0; i < 3; i++) begin
            if (flush) begin
                rd[i] <= wr[i];
            end else if (fifo_pop[i]) begin
                if (rd[i] == wr[i]) viol++;
                log_ch.push_back(i);
                log_dat.push_back(mem[i][rd[i]]);
                rd[i] <= rd[i] + 8'd1;
            end
        end
    end

    task automatic push(input int ch, input logic [7:0] b);
        mem[ch][wr[ch]] = b;
        wr[ch] = wr[ch] + 8'd1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant got=%b exp=000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (data_out_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", data_out_req); end
        checks++; if (fifo_pop !== 3'b000) begin errors++; $display("FAIL reset_pop got=%b exp=000", fifo_pop); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int base, cnt, gbad;
        logic [7:0] exp_d [4];
        exp_d = '{8'h03, 8'hA1, 8'hA2, 8'hA3};
        base = log_dat.size();
        crc = 1'b0; ack = 1'b1;
        push(1, 8'h03); push(1, 8'hA1); push(1, 8'hA2); push(1, 8'hA3);
        cnt = 0; gbad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (busy) begin
                cnt++;
                if (grant !== 3'b010) gbad++;
            end else if (cnt > 0) break;
        end
        checks++; if (cnt != 8) begin errors++; $display("FAIL single_busy_cycles got=%0d exp=8", cnt); end
        checks++; if (gbad != 0) begin errors++; $display("FAIL single_grant bad_cycles=%0d exp=0", gbad); end
        checks++; if (busy !== 1'b0 || grant !== 3'b000) begin errors++; $display("FAIL single_end busy=%b grant=%b exp 0/000", busy, grant); end
        checks++;
        if (log_dat.size() != base + 4) begin
            errors++; $display("FAIL single_pops got=%0d exp=4", log_dat.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_ch[base+i] != 1 || log_dat[base+i] !== exp_d[i]) begin
                    errors++; $display("FAIL single_byte%0d got=ch%0d/%h exp=ch1/%h", i, log_ch[base+i], log_dat[base+i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_round_robin;
        logic [2:0] seen [$];
        logic [2:0] prev;
        logic [2:0] exp_g [4];
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        rst_n = 1'b0;
        for (int ch = 0; ch < 3; ch++) begin push(ch, 8'h00); push(ch, 8'h00); end
        @(negedge clk);
        rst_n = 1'b1;
        prev = 3'b000;
        for (int c = 0; c < 80 && seen.size() < 6; c++) begin
            @(negedge clk);
            if (grant != 3'b000 && prev == 3'b000) seen.push_back(grant);
            prev = grant;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen.size() <= i) begin
                errors++; $display("FAIL rr_grant%0d missing exp=%b", i, exp_g[i]);
            end else if (seen[i] !== exp_g[i]) begin
                errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, seen[i], exp_g[i]);
            end
        end
        repeat (4) @(negedge clk);
        checks++; if (fifo_empty !== 3'b111 || busy !== 1'b0) begin errors++; $display("FAIL rr_drain empty=%b busy=%b exp 111/0", fifo_empty, busy); end
    endtask

    task automatic test_crc;
        int base, cnt;
        logic [7:0] exp_d [4];
        exp_d = '{8'h02, 8'hB1, 8'hB2, 8'hC9};
        base = log_dat.size();
        crc = 1'b1; ack = 1'b1;
        push(2, 8'h02); push(2, 8'hB1); push(2, 8'hB2); push(2, 8'hC9);
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (busy) begin
                cnt++;
                if (cnt == 3) crc = 1'b0;   // must not shorten the packet in flight
            end else if (cnt > 0) break;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL crc_done busy=%b exp=0", busy); end
        checks++;
        if (log_dat.size() != base + 4) begin
            errors++; $display("FAIL crc_pops got=%0d exp=4", log_dat.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_ch[base+i] != 2 || log_dat[base+i] !== exp_d[i]) begin
                    errors++; $display("FAIL crc_byte%0d got=ch%0d/%h exp=ch2/%h", i, log_ch[base+i], log_dat[base+i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_underflow;
        int base;
        logic [7:0] exp_d [5];
        exp_d = '{8'h04, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
        base = log_dat.size();
        crc = 1'b0; ack = 1'b1;
        push(0, 8'h04); push(0, 8'hD1);
        push(2, 8'h00);
        repeat (20) @(negedge clk);
        checks++; if (log_dat.size() != base + 2) begin errors++; $display("FAIL uf_partial_pops got=%0d exp=2", log_dat.size() - base); end
        checks++; if (data_out_req !== 1'b0) begin errors++; $display("FAIL uf_req got=%b exp=0", data_out_req); end
        checks++; if (grant !== 3'b001 || busy !== 1'b1) begin errors++; $display("FAIL uf_hold grant=%b busy=%b exp 001/1", grant, busy); end
        push(0, 8'hD2); push(0, 8'hD3); push(0, 8'hD4);
        repeat (30) @(negedge clk);
        checks++;
        if (log_dat.size() != base + 6) begin
            errors++; $display("FAIL uf_total_pops got=%0d exp=6", log_dat.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (log_ch[base+i] != 0 || log_dat[base+i] !== exp_d[i]) begin
                    errors++; $display("FAIL uf_byte%0d got=ch%0d/%h exp=ch0/%h", i, log_ch[base+i], log_dat[base+i], exp_d[i]);
                end
            end
            checks++; if (log_ch[base+5] != 2) begin errors++; $display("FAIL uf_next_ch got=%0d exp=2", log_ch[base+5]); end
        end
    endtask

    task automatic test_ack_stall;
        int base, bad_req, bad_dat, bad_rem, bad_pop;
        base = log_dat.size();
        ack = 1'b0; crc = 1'b0;
        push(0, 8'h02); push(0, 8'hE1); push(0, 8'hE2);
        @(negedge clk);                      // pick edge passed: HEADER, req up
        checks++; if (busy !== 1'b1 || data_out_req !== 1'b1) begin errors++; $display("FAIL stall_start busy=%b req=%b exp 1/1", busy, data_out_req); end
        ack = 1'b1;
        @(negedge clk);                      // header taken, now in GAP
        ack = 1'b0;
        @(negedge clk);                      // DATA with first payload byte requested
        bad_req = 0; bad_dat = 0; bad_rem = 0; bad_pop = 0;
        for (int c = 0; c < 10; c++) begin
            if (data_out_req !== 1'b1) bad_req++;
            if (data_out !== 8'hE1) bad_dat++;
            if (dut.rem_r !== 7'd2) bad_rem++;
            if (fifo_pop !== 3'b000) bad_pop++;
            @(negedge clk);
        end
        checks++; if (bad_req != 0) begin errors++; $display("FAIL stall_req_drop cycles=%0d exp=0", bad_req); end
        checks++; if (bad_dat != 0) begin errors++; $display("FAIL stall_data_change cycles=%0d exp=0", bad_dat); end
        checks++; if (bad_rem != 0) begin errors++; $display("FAIL stall_rem_change cycles=%0d exp=0", bad_rem); end
        checks++; if (bad_pop != 0 || log_dat.size() != base + 1) begin errors++; $display("FAIL stall_pop bad=%0d pops=%0d exp 0/1", bad_pop, log_dat.size() - base); end
        ack = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (log_dat.size() != base + 3 || busy !== 1'b0) begin errors++; $display("FAIL stall_finish pops=%0d busy=%b exp 3/0", log_dat.size() - base, busy); end
    endtask

    task automatic test_reset_mid;
        int base;
        ack = 1'b1; crc = 1'b0;
        push(2, 8'h05);
        for (int i = 1; i <= 5; i++) push(2, 8'hF0 + 8'(i));
        repeat (4) @(negedge clk);
        push(0, 8'h00);
        checks++; if (grant !== 3'b100 || busy !== 1'b1) begin errors++; $display("FAIL mid_owner grant=%b busy=%b exp 100/1", grant, busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (grant !== 3'b000 || busy !== 1'b0 || data_out_req !== 1'b0 || fifo_pop !== 3'b000 || data_out !== 8'h00) begin
            errors++; $display("FAIL mid_reset_outputs grant=%b busy=%b req=%b pop=%b data=%h exp all 0", grant, busy, data_out_req, fifo_pop, data_out);
        end
        base = log_dat.size();
        flush = 1'b1;
        @(negedge clk);                      // discard the abandoned ch2 remainder...
        flush = 1'b0;
        push(0, 8'h00);                      // ...flush also cleared ch0, so requeue its header
        @(negedge clk);
        checks++; if (log_dat.size() != base) begin errors++; $display("FAIL mid_pop_in_reset pops=%0d exp=0", log_dat.size() - base); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL mid_next_grant got=%b exp=001", grant); end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ack = 1'b0; crc = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin rd[i] = 8'd0; wr[i] = 8'd0; end
        test_reset();
        test_single();
        test_round_robin();
        test_crc();
        test_underflow();
        test_ack_stall();
        test_reset_mid();
        checks++; if (viol != 0) begin errors++; $display("FAIL pop_protocol violations=%0d exp=0", viol); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
